// File: rtl/prog_counter.sv
// Up/down counter with programmable modulus, clock-enable prescaler,
// parallel load and wrap-or-saturate behaviour at the terminal value.
module prog_counter #(
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned MAX      = (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1),
  parameter int unsigned PRESCALE = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Tick,
  output logic             TC
);

  localparam int unsigned      PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    P_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    P_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             at_limit;

  // Tick deliberately excludes D and Up so it can cascade without long paths.
  assign Tick     = En & ~Load & Resetn & (p_q == P_LAST);
  assign at_limit = Up ? (q_q == MAX_W) : (q_q == '0);

  always_comb begin
    p_d  = p_q;
    q_d  = q_q;
    tc_d = 1'b0;
    if (Load) begin
      q_d = (D > MAX_W) ? MAX_W : D;
      p_d = '0;
    end else if (En) begin
      p_d = (p_q == P_LAST) ? '0 : p_q + P_ONE;
      if (Tick) begin
        tc_d = at_limit;
        if (!at_limit) begin
          q_d = Up ? q_q + ONE_W : q_q - ONE_W;
        end else if (!SATURATE) begin
          q_d = Up ? '0 : MAX_W;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      p_q  <= '0;
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      p_q  <= p_d;
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign Q  = q_q;
  assign TC = tc_q;

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised up/down counter with programmable modulus, clock-enable prescaler, parallel load and wrap or saturate mode. It replaces the fixed-width free-running counter in board demos and timing blocks. The top level drives Clock from CLOCK_50 and Resetn from KEY[0], and shows Q, or its upper bits, on LEDR. TC and Tick can cascade further instances.

## Interface
- WIDTH, 24: counter width in bits; range 1..32.
- MAX, 2**WIDTH-1: terminal value. Q counts 0..MAX. Must satisfy 0 < MAX ≤ 2**WIDTH-1.
- PRESCALE, 1: step once every PRESCALE enabled clocks; range ≥1.
- SATURATE, 0: 0 = wrap at the terminal value, 1 = hold at the terminal value.
- Clock  in  1  rising-edge clock, the only clock.
- Resetn  in  1  synchronous, active-low reset.
- En  in  1  count enable; gates the prescaler and stepping.
- Up  in  1  direction: 1 = increment, 0 = decrement.
- Load  in  1  parallel load strobe.
- D  in  WIDTH  load value.
- Q  out  WIDTH  registered count.
- Tick  out  1  combinational step strobe: a step occurs this cycle.
- TC  out  1  registered terminal-count pulse.

## Operation
- Prescaler P is a register ceil(log2(PRESCALE)) bits wide, minimum 1 bit. It counts 0..PRESCALE-1 on enabled clocks and wraps to 0.
- Tick = En & ~Load & Resetn & (P == PRESCALE-1). When PRESCALE=1, Tick = En & ~Load & Resetn.
- P behaviour:
  - Holds when En=0.
  - Clears to 0 on Load or reset.
- Priority per edge: reset > Load > Tick step > hold.
- Reset (Resetn=0 at the edge): Q←0, P←0, TC←0.
- Load=1: Q←min(D, MAX), P←0, TC←0. Load ignores En and Up. No step occurs that cycle.
- Tick step with Up=1:
  - Q<MAX: Q←Q+1.
  - Q==MAX: Q←0 if SATURATE=0, else Q stays MAX.
- Tick step with Up=0:
  - Q>0: Q←Q-1.
  - Q==0: Q←MAX if SATURATE=0, else Q stays 0.
- TC←1 on a Tick edge where Q held the terminal value (MAX when Up=1, 0 when Up=0). Otherwise TC←0.
  - TC is a single-cycle pulse per qualifying Tick.
  - In saturate mode TC pulses on every Tick while Q sits at the limit.
- Up may change on any cycle. It is sampled only on Tick edges, and the step uses the Up value present on that edge.
- Q outside 0..MAX cannot occur, because Load clamps D.
- Arithmetic is WIDTH bits with no carry out. The MAX compare is a full-width equality.

## Timing
- All outputs are registered except Tick. Tick is combinational from P, En, Load and Resetn, with no combinational path from D or Up.
- Q and TC change on the rising edge that samples Tick=1 or Load=1, so latency is 1 clock.
- With En held high, the Tick period is exactly PRESCALE clocks. The first Tick after reset or Load comes PRESCALE enabled clocks later.
- Deasserting En mid-prescale freezes P. Reasserting En resumes from the frozen value, with no extra or lost cycles.
- Reset mid-count takes effect on the next edge regardless of En or Load. Tick reads 0 while Resetn=0.
- Reset values: Q=0, TC=0, Tick=0, P=0.

## Test plan
All scenarios use WIDTH=4, MAX=9, PRESCALE=3, SATURATE=0 unless noted.
- Reset: hold Resetn=0 for 2 clocks with En=Up=Load=1, D=5 → Q=0, TC=0, Tick=0 throughout. After release, the first Tick comes on the 3rd clock.
- Up wrap: En=1, Up=1 for 30 clocks after reset.
  - Tick is high on clocks 3, 6, …, 30.
  - Q goes 1..9, then 0 on the 10th Tick.
  - TC is high for exactly the one cycle after that edge; no other TC pulses.
- Down wrap: from Q=0, set Up=0, En=1 → on the next Tick Q=9 and TC pulses once. Further Ticks give 8, 7, … with TC=0.
- Load:
  - En=0, D=7, Load=1 for one clock → Q=7.
  - D=12 → Q=9 (clamped).
  - Load asserted on a Tick cycle → Q=D, no step, P=0, and the next Tick comes 3 clocks later.
- Saturate (SATURATE=1), Up=1 from Q=8: Ticks give 9, 9, 9. TC pulses on the 2nd and 3rd Ticks only.
- En gating and reset mid-count:
  - From P=1, drop En for 5 clocks → Q and P frozen. Re-enable → Tick after 1 further clock.
  - With Q=6, assert Resetn=0 for one clock → Q=0 and TC=0 on that edge.
